// File: rtl/dsp_mac_arb_pkg.sv
// Shared definitions for dsp_mac_arbiter: default widths, tag width helper
// and the issue-stage record.
package dsp_mac_arb_pkg;

    localparam int unsigned DATA_W  = 8;
    localparam int unsigned NUM_REQ = 4;

    // Tag width for n requesters; never narrower than one bit.
    function automatic int unsigned calc_id_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    localparam int unsigned ID_W  = calc_id_w(NUM_REQ);
    localparam int unsigned RES_W = 2 * DATA_W;

    // Operands and requester tag captured in the issue stage.
    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [DATA_W-1:0] c;
        logic [ID_W-1:0]   id;
    } issue_t;

endpackage

// File: rtl/dsp_mac_arbiter_if.sv
// Request/result bus between the requesters and dsp_mac_arbiter.
//   req_valid/req_ready : per-requester handshake (ready is one-hot or zero)
//   req_a/b/c           : packed operands, requester i at [i*DATA_W +: DATA_W]
//   out_valid/out_ready : result handshake
//   out_result, out_id  : a*b+c and the tag of the issuing requester
//   busy                : any operation in flight
// master = requester/downstream side, slave = the arbiter.
interface dsp_mac_arbiter_if;
    import dsp_mac_arb_pkg::*;

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*DATA_W-1:0] req_a;
    logic [NUM_REQ*DATA_W-1:0] req_b;
    logic [NUM_REQ*DATA_W-1:0] req_c;
    logic                      out_valid;
    logic                      out_ready;
    logic [RES_W-1:0]          out_result;
    logic [ID_W-1:0]           out_id;
    logic                      busy;

    modport master (
        output req_valid, req_a, req_b, req_c, out_ready,
        input  req_ready, out_valid, out_result, out_id, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, req_c, out_ready,
        output req_ready, out_valid, out_result, out_id, busy
    );

endinterface

// File: rtl/dsp_mac_arbiter_rr_arbiter.sv
// rr_arbiter: picks one requester per cycle for the shared MAC.
//   clk, reset : clock and synchronous active-high reset (round-robin build only)
//   req        : request vector
//   en         : arbitration allowed this cycle
//   gnt_c      : one-hot grant (combinational)
//   gnt_idx_c  : encoded grant index (combinational)
// Build option DSP_MAC_ARB_FIXED_PRIO_EN: lowest index wins, no pointer.
module rr_arbiter
    import dsp_mac_arb_pkg::*;
(
`ifndef DSP_MAC_ARB_FIXED_PRIO_EN
    input  logic               clk,
    input  logic               reset,
`endif
    input  logic [NUM_REQ-1:0] req,
    input  logic               en,
    output logic [NUM_REQ-1:0] gnt_c,
    output logic [ID_W-1:0]    gnt_idx_c
);

`ifdef DSP_MAC_ARB_FIXED_PRIO_EN

    // Scan downward so the lowest requesting index is the last writer.
    always_comb begin
        gnt_c     = '0;
        gnt_idx_c = '0;
        for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
            if (en && req[k]) begin
                gnt_c     = '0;
                gnt_c[k]  = 1'b1;
                gnt_idx_c = ID_W'(k);
            end
        end
    end

`else

    logic [ID_W-1:0] ptr;
    logic [ID_W:0]   sum;
    logic [ID_W-1:0] idx;
    logic            found;

    // First requester at or after ptr, wrapping modulo NUM_REQ.
    always_comb begin
        gnt_c     = '0;
        gnt_idx_c = '0;
        found     = 1'b0;
        sum       = '0;
        idx       = '0;
        if (en) begin
            for (int k = 0; k < int'(NUM_REQ); k++) begin
                sum = {1'b0, ptr} + (ID_W+1)'(k);
                if (sum >= (ID_W+1)'(NUM_REQ)) begin
                    sum = sum - (ID_W+1)'(NUM_REQ);
                end
                idx = sum[ID_W-1:0];
                if (!found && req[idx]) begin
                    found       = 1'b1;
                    gnt_c[idx]  = 1'b1;
                    gnt_idx_c   = idx;
                end
            end
        end
    end

    // Pointer moves just past the winner; idle cycles leave it alone.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (|gnt_c) begin
            if (gnt_idx_c == ID_W'(NUM_REQ - 1)) begin
                ptr <= '0;
            end else begin
                ptr <= gnt_idx_c + ID_W'(1);
            end
        end
    end

`endif

endmodule

// File: rtl/dsp_mac_arbiter.sv
// dsp_mac_arbiter: shares one registered multiply-add (a*b + c) among
// NUM_REQ requesters. Issue stage S1 holds the granted operands, compute
// stage S2 is the output register.
//   clk   : clock
//   reset : synchronous active-high reset, discards in-flight work
//   bus   : dsp_mac_arbiter_if.slave (requests, result, busy)
// Build option DSP_MAC_ARB_FIXED_PRIO_EN selects fixed priority arbitration.
module dsp_mac_arbiter
    import dsp_mac_arb_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    dsp_mac_arbiter_if.slave bus
);

    issue_t            s1_q;
    issue_t            s1_d;
    logic              s1_valid;
    logic              out_valid_q;
    logic [RES_W-1:0]  out_result_q;
    logic [ID_W-1:0]   out_id_q;

    logic              s2_load;
    logic              s1_accept;
    logic              arb_en;
    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]   gnt_idx;
    logic [RES_W-1:0]  mac;

    logic [DATA_W-1:0] a_arr [NUM_REQ];
    logic [DATA_W-1:0] b_arr [NUM_REQ];
    logic [DATA_W-1:0] c_arr [NUM_REQ];

    // Unpack the flat operand buses so the grant index can select directly.
    for (genvar g = 0; g < int'(NUM_REQ); g++) begin : g_unpack
        assign a_arr[g] = bus.req_a[g*DATA_W +: DATA_W];
        assign b_arr[g] = bus.req_b[g*DATA_W +: DATA_W];
        assign c_arr[g] = bus.req_c[g*DATA_W +: DATA_W];
    end

    // S2 takes new data when empty or draining; S1 refills behind it.
    assign s2_load   = !out_valid_q || bus.out_ready;
    assign s1_accept = !s1_valid || s2_load;
    assign arb_en    = s1_accept && !reset;

    rr_arbiter u_arb (
`ifndef DSP_MAC_ARB_FIXED_PRIO_EN
        .clk       (clk),
        .reset     (reset),
`endif
        .req       (bus.req_valid),
        .en        (arb_en),
        .gnt_c     (gnt),
        .gnt_idx_c (gnt_idx)
    );

    always_comb begin
        s1_d.a  = a_arr[gnt_idx];
        s1_d.b  = b_arr[gnt_idx];
        s1_d.c  = c_arr[gnt_idx];
        s1_d.id = gnt_idx;
    end

    // Unsigned MAC; c is zero-extended and the sum cannot overflow RES_W.
    assign mac = RES_W'(s1_q.a) * RES_W'(s1_q.b) + RES_W'(s1_q.c);

    // Pipeline registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid     <= 1'b0;
            s1_q         <= '0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_id_q     <= '0;
        end else begin
            if (s2_load) begin
                out_valid_q <= s1_valid;
                if (s1_valid) begin
                    out_result_q <= mac;
                    out_id_q     <= s1_q.id;
                end
            end
            if (s1_accept) begin
                s1_valid <= |gnt;
                if (|gnt) begin
                    s1_q <= s1_d;
                end
            end
        end
    end

    assign bus.req_ready  = gnt;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_result = out_result_q;
    assign bus.out_id     = out_id_q;
    assign bus.busy       = s1_valid | out_valid_q;

endmodule

// File: tb/tb_dsp_mac_arbiter.sv
// Self-checking bench for dsp_mac_arbiter: table of single operations plus
// sequences for round-robin order, backpressure, mid-stream reset and the
// arbitration mode selected by DSP_MAC_ARB_FIXED_PRIO_EN.
module tb_dsp_mac_arbiter;
    import dsp_mac_arb_pkg::*;

    logic clk = 1'b0;
    logic reset;

    dsp_mac_arbiter_if bus();

    dsp_mac_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int               id;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [DATA_W-1:0] c;
        logic [RES_W-1:0]  exp_res;
    } vec_t;

    typedef struct {
        int               id;
        logic [RES_W-1:0] res;
        int               cyc;
    } sb_t;

    vec_t vecs [8];
    sb_t  sbq [$];

    logic [NUM_REQ-1:0] drv_valid;
    logic [DATA_W-1:0]  cur_a   [NUM_REQ];
    logic [DATA_W-1:0]  cur_b   [NUM_REQ];
    logic [DATA_W-1:0]  cur_c   [NUM_REQ];
    logic [RES_W-1:0]   cur_exp [NUM_REQ];
    int                 pend    [NUM_REQ];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int last_grant;
    logic [NUM_REQ-1:0] last_ready;
    logic chk_lat = 1'b0;
    logic prev_hold = 1'b0;
    logic [RES_W-1:0] prev_res;
    logic [ID_W-1:0]  prev_id;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive();
        bus.req_valid = drv_valid;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            bus.req_a[i*DATA_W +: DATA_W] = cur_a[i];
            bus.req_b[i*DATA_W +: DATA_W] = cur_b[i];
            bus.req_c[i*DATA_W +: DATA_W] = cur_c[i];
        end
    endtask

    task automatic load_op(input int i, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                           input logic [DATA_W-1:0] c, input logic [RES_W-1:0] e);
        cur_a[i]     = a;
        cur_b[i]     = b;
        cur_c[i]     = c;
        cur_exp[i]   = e;
        drv_valid[i] = 1'b1;
    endtask

    task automatic load_rand(input int i);
        logic [DATA_W-1:0] a, b, c;
        a = DATA_W'($urandom_range(0, 255));
        b = DATA_W'($urandom_range(0, 255));
        c = DATA_W'($urandom_range(0, 255));
        load_op(i, a, b, c, RES_W'(a) * RES_W'(b) + RES_W'(c));
    endtask

    // One clock: monitor at negedge, requester updates just after posedge.
    task automatic cycle();
        logic [NUM_REQ-1:0] acc;
        sb_t e;
        @(negedge clk);
        cyc++;
        last_ready = bus.req_ready;
        acc = bus.req_valid & bus.req_ready;
        last_grant = -1;
        check("ready_onehot", 32'($onehot0(bus.req_ready)), 32'd1);
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (acc[i]) begin
                last_grant = i;
                sbq.push_back('{i, cur_exp[i], cyc});
            end
        end
        if (prev_hold) begin
            check("hold_valid",  32'(bus.out_valid),  32'd1);
            check("hold_result", 32'(bus.out_result), 32'(prev_res));
            check("hold_id",     32'(bus.out_id),     32'(prev_id));
        end
        if (bus.out_valid && bus.out_ready) begin
            if (sbq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL spurious_result: got 0x%0h id %0d with nothing expected (cycle %0d)",
                         bus.out_result, bus.out_id, cyc);
            end else begin
                e = sbq.pop_front();
                check("result", 32'(bus.out_result), 32'(e.res));
                check("out_id", 32'(bus.out_id), 32'(e.id));
                if (chk_lat) check("latency", 32'(cyc - e.cyc), 32'd2);
            end
        end
        prev_hold = bus.out_valid && !bus.out_ready && !reset;
        prev_res  = bus.out_result;
        prev_id   = bus.out_id;
        @(posedge clk);
        #1;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (acc[i]) begin
                if (pend[i] > 0) begin
                    pend[i]--;
                    load_rand(i);
                end else begin
                    drv_valid[i] = 1'b0;
                end
            end
        end
        drive();
    endtask

    task automatic drain(input string tag, input int budget);
        int n;
        n = 0;
        while ((drv_valid != '0 || sbq.size() != 0) && n < budget) begin
            cycle();
            n++;
        end
        if (drv_valid != '0 || sbq.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: got %0d results outstanding, valid 0x%0h expected none",
                     tag, sbq.size(), drv_valid);
            sbq.delete();
            drv_valid = '0;
            for (int i = 0; i < int'(NUM_REQ); i++) pend[i] = 0;
            drive();
        end
        check({tag, "_idle_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_idle_busy"},  32'(bus.busy),      32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_ready",  32'(bus.req_ready),  32'd0);
        check("rst_valid",  32'(bus.out_valid),  32'd0);
        check("rst_result", 32'(bus.out_result), 32'd0);
        check("rst_id",     32'(bus.out_id),     32'd0);
        check("rst_busy",   32'(bus.busy),       32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        sbq.delete();
        prev_hold = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{2,   8'd3,   8'd5,   8'd7, 16'd22};
        vecs[1] = '{0, 8'd255, 8'd255, 8'd255, 16'hFF00};
        vecs[2] = '{1,   8'd0,   8'd0,   8'd0, 16'd0};
        vecs[3] = '{3,  8'd16,  8'd16,   8'd1, 16'd257};
        vecs[4] = '{1, 8'd200,   8'd2,  8'd55, 16'd455};
        vecs[5] = '{0,   8'd1, 8'd255,   8'd0, 16'd255};
        vecs[6] = '{3, 8'd255,   8'd1, 8'd255, 16'd510};
        vecs[7] = '{2, 8'd128,   8'd2,   8'd0, 16'd256};

        reset         = 1'b1;
        bus.out_ready = 1'b0;
        drv_valid     = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            cur_a[i] = '0; cur_b[i] = '0; cur_c[i] = '0; cur_exp[i] = '0; pend[i] = 0;
        end

        // Reset with every requester asking: ready must stay low.
        for (int i = 0; i < int'(NUM_REQ); i++) load_rand(i);
        drive();
        do_reset();
        chk_lat       = 1'b1;
        bus.out_ready = 1'b1;
        drain("init", 50);

        // Table of isolated operations.
        for (int v = 0; v < 8; v++) begin
            load_op(vecs[v].id, vecs[v].a, vecs[v].b, vecs[v].c, vecs[v].exp_res);
            drive();
            drain("vec", 20);
        end

        // Round-robin order with all requesters busy.
        do_reset();
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            pend[i] = 7;
            load_rand(i);
        end
        drive();
        for (int k = 0; k < 32; k++) begin
            cycle();
            check("rr_order", 32'(last_grant), 32'(k % 4));
        end
        drain("rr", 20);

        // Backpressure: S2 and S1 fill, then requests are held off.
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            pend[i] = 4;
            load_rand(i);
        end
        bus.out_ready = 1'b0;
        chk_lat       = 1'b0;
        drive();
        for (int k = 0; k < 5; k++) begin
            cycle();
            if (k >= 2) begin
                check("bp_ready_low", 32'(last_ready), 32'd0);
                check("bp_out_valid", 32'(bus.out_valid), 32'd1);
            end
        end
        bus.out_ready = 1'b1;
        drain("bp", 100);
        chk_lat = 1'b1;

        // Reset with two operations in flight.
        pend[1] = 3;
        pend[2] = 3;
        load_rand(1);
        load_rand(2);
        drive();
        cycle();
        cycle();
        check("pre_rst_busy", 32'(bus.busy), 32'd1);
        bus.out_ready = 1'b0;
        reset         = 1'b1;
        cycle();
        check("mid_rst_ready", 32'(last_ready), 32'd0);
        reset = 1'b0;
        sbq.delete();
        prev_hold = 1'b0;
        check("post_rst_valid", 32'(bus.out_valid), 32'd0);
        check("post_rst_busy",  32'(bus.busy),      32'd0);
        load_rand(0);
        load_rand(3);
        bus.out_ready = 1'b1;
        drive();
        cycle();
        check("post_rst_grant", 32'(last_grant), 32'd0);
        drain("rst", 60);

        // Requesters 1 and 3 both asking.
        do_reset();
        pend[1] = 5;
        pend[3] = 5;
        load_rand(1);
        load_rand(3);
        drive();
        for (int k = 0; k < 6; k++) begin
            cycle();
`ifdef DSP_MAC_ARB_FIXED_PRIO_EN
            check("prio_grant", 32'(last_grant), 32'd1);
`else
            check("prio_grant", 32'(last_grant), (k % 2 == 0) ? 32'd1 : 32'd3);
`endif
        end
        drain("prio", 40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dsp_mac_arbiter.md
# dsp_mac_arbiter

Shares a single registered multiply-add datapath (result = a*b + c) among NUM_REQ independent requesters. Grants one requester per cycle by round-robin arbitration, pipelines the operation through an issue stage and a compute stage, and returns the result tagged with the requester index over a valid/ready output. It sits between the requester blocks and the DSP resource so that one multiplier is reused by all requesters.

## Interface
- DATA_W, 8, operand width of a, b and c
- NUM_REQ, 4, number of requesters, 2..16
- ID_W, $clog2(NUM_REQ), width of the requester tag (localparam)
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester grant/accept; at most one bit high
- req_a  in  NUM_REQ*DATA_W  packed operand a; requester i at [i*DATA_W +: DATA_W]
- req_b  in  NUM_REQ*DATA_W  packed operand b, same packing
- req_c  in  NUM_REQ*DATA_W  packed operand c, same packing
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_result  out  2*DATA_W  a*b + c
- out_id  out  ID_W  index of the requester that issued this result
- busy  out  1  high while any operation is in flight

## Operation
- Request transfer on requester i: req_valid[i] && req_ready[i] at a rising edge. Requesters hold valid and operands stable until accepted.
- Issue stage (S1) holds a, b, c and id. Compute stage (S2) is the output register.
- Pipeline advance:
  - S2 loads when S2 is empty or out_ready is high.
  - S1 accepts a request when S1 is empty or S1 moves into S2 in the same cycle.
- Arbitration:
  - Runs only when S1 can accept.
  - Round-robin from pointer ptr: the first i in ptr, ptr+1, … (mod NUM_REQ) with req_valid[i]=1 gets req_ready[i]=1.
  - On a grant, ptr becomes (i+1) mod NUM_REQ. With no grant, ptr is unchanged.
- req_ready is combinational from req_valid, ptr and stall state. It is forced to all zeros while reset is high.
- Arithmetic: unsigned. The a*b product is 2*DATA_W wide. c is zero-extended before the add. No overflow is possible, since the maximum value is 2^(2*DATA_W) − 2^DATA_W.
- busy = S1 valid | out_valid.

## Timing
- Reset values: out_valid=0, out_result=0, out_id=0, S1 valid=0, ptr=0, busy=0, req_ready=0.
- Latency: request accepted at edge N drives out_valid=1 with the result from edge N+2.
- Throughput: one operation per cycle while out_ready stays high.
- Backpressure:
  - out_valid=1 with out_ready=0 holds out_result and out_id stable.
  - S1 fills and then all req_ready go low. No result is dropped or duplicated.
- Simultaneous events: when S2 drains and S1 refills in the same cycle, both happen and full throughput is kept.
- Reset mid-operation: all in-flight operations are discarded. No out_valid appears for them after reset deasserts.
- No req_valid: no grant and the pipeline drains normally.

## Configuration
- Macro DSP_MAC_ARB_FIXED_PRIO_EN.
- Defined: fixed priority. The lowest index with req_valid wins and ptr is not implemented.
- Undefined (default): round-robin as described above.
- Ports and latency are identical in both builds.

## Structure
- Package dsp_mac_arb_pkg holds:
  - default DATA_W and NUM_REQ
  - a function computing ID_W
  - a typedef for the issue-stage record {a, b, c, id}
- Sub-module rr_arbiter contains:
  - inputs: the NUM_REQ request vector and an enable
  - outputs: a one-hot grant and the encoded grant index
  - the ptr register, with fixed priority under the macro
- The top level contains the S1/S2 registers, the stall logic and the multiply-add.

## Test plan
- Single op: requester 2 sends a=3, b=5, c=7 with out_ready=1. Expect out_result=22 and out_id=2 exactly two cycles after acceptance.
- Round-robin fairness: all four requesters valid continuously with out_ready=1. Expect the grant order 0,1,2,3,0,1… and one result per cycle.
- Max values: DATA_W=8, a=b=c=255. Expect out_result=65280 (0xFF00).
- Backpressure: out_ready=0 for 5 cycles with all requesters valid. Expect out_result and out_id stable and req_ready all 0 after S1 fills. On out_ready=1, expect results in grant order with none lost.
- Reset mid-stream: assert reset for one cycle with two ops in flight. Expect out_valid=0, req_ready=0 and no stale results afterwards. The next grant goes to requester 0.
- Fixed-priority build: with DSP_MAC_ARB_FIXED_PRIO_EN defined and requesters 1 and 3 continuously valid, expect only requester 1 to be granted.
